id_stage_reg: RTL

ID_STAGE_REG -- requirements
Module: id_stage_reg

---
 rtl/arm_pkg.sv | 41 ++++
 rtl/id_stage_reg_if.sv | 57 +++++
 rtl/pipe_reg.sv | 22 ++
 rtl/id_stage_reg.sv | 94 +++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared decode-stage widths, control/status bit positions and small helpers.
// Control bits are packed {wb_en, mem_r_en, mem_w_en, s, b}; status bits {N, Z, C, V}.
package arm_pkg;

  localparam int EXE_CMD_W    = 4;
  localparam int REG_IDX_W    = 4;
  localparam int CTRL_W       = 5;
  localparam int STATUS_W     = 4;
  localparam int BUBBLE_CNT_W = 16;

  localparam int WB_EN    = 4;
  localparam int MEM_R_EN = 3;
  localparam int MEM_W_EN = 2;
  localparam int S_BIT    = 1;
  localparam int B_BIT    = 0;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic wb_en;
    logic mem_r_en;
    logic mem_w_en;
    logic s;
    logic b;
  } ctrl_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_t;

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    return (v == {BUBBLE_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/id_stage_reg_if.sv
// Decode-to-execute pipeline boundary: upstream control, decoded fields in, registered fields out.
// slave = the pipeline register itself, master = the decode stage / bench driving it.
interface id_stage_reg_if;
  import arm_pkg::*;

  logic                    stall;
  logic                    flush;
  logic                    hazard;

  logic [31:0]             pc_in;
  logic [31:0]             val_rn_in;
  logic [31:0]             val_rm_in;
  logic [11:0]             shift_operand_in;
  logic                    imm_in;
  logic [EXE_CMD_W-1:0]    exe_cmd_in;
  logic [CTRL_W-1:0]       ctrl_in;
  logic [REG_IDX_W-1:0]    dest_in;
  logic [REG_IDX_W-1:0]    src1_in;
  logic [REG_IDX_W-1:0]    src2_in;
  logic [23:0]             signed_imm_24_in;
  logic [STATUS_W-1:0]     status_in;

  logic [31:0]             pc_out;
  logic [31:0]             val_rn_out;
  logic [31:0]             val_rm_out;
  logic [11:0]             shift_operand_out;
  logic                    imm_out;
  logic [EXE_CMD_W-1:0]    exe_cmd_out;
  logic [CTRL_W-1:0]       ctrl_out;
  logic [REG_IDX_W-1:0]    dest_out;
  logic [REG_IDX_W-1:0]    src1_out;
  logic [REG_IDX_W-1:0]    src2_out;
  logic [23:0]             signed_imm_24_out;
  logic [STATUS_W-1:0]     status_out;
  logic                    valid_out;
  logic                    mem_sel_out;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt;

  modport slave (
    input  stall, flush, hazard,
    input  pc_in, val_rn_in, val_rm_in, shift_operand_in, imm_in, exe_cmd_in,
    input  ctrl_in, dest_in, src1_in, src2_in, signed_imm_24_in, status_in,
    output pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out, exe_cmd_out,
    output ctrl_out, dest_out, src1_out, src2_out, signed_imm_24_out, status_out,
    output valid_out, mem_sel_out, bubble_cnt
  );

  modport master (
    output stall, flush, hazard,
    output pc_in, val_rn_in, val_rm_in, shift_operand_in, imm_in, exe_cmd_in,
    output ctrl_in, dest_in, src1_in, src2_in, signed_imm_24_in, status_in,
    input  pc_out, val_rn_out, val_rm_out, shift_operand_out, imm_out, exe_cmd_out,
    input  ctrl_out, dest_out, src1_out, src2_out, signed_imm_24_out, status_out,
    input  valid_out, mem_sel_out, bubble_cnt
  );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline field register: en gates the update, clr loads zero instead of d.
// One-cycle latency; en low holds the current value (clr ignored while held).
module pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: captures decoded fields, inserts zero bubbles on flush/hazard, counts them.
// One-cycle latency; stall freezes every output (including the bubble count) and overrides flush/hazard.
module id_stage_reg
  import arm_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  id_stage_reg_if.slave bus
);

  logic load_en;
  logic kill;

  ctrl_t   ctrl_d;
  status_t status_d;

  logic [36:0]             opnd_q;
  logic [12:0]             ctl_q;
  logic [7:0]              src_q;
  logic [STATUS_W-1:0]     status_q;
  logic                    valid_q;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_q;

  assign load_en = ~bus.stall;
  assign kill    = bus.flush | bus.hazard;

  assign ctrl_d = '{wb_en:    bus.ctrl_in[WB_EN],
                    mem_r_en: bus.ctrl_in[MEM_R_EN],
                    mem_w_en: bus.ctrl_in[MEM_W_EN],
                    s:        bus.ctrl_in[S_BIT],
                    b:        bus.ctrl_in[B_BIT]};

  assign status_d = '{n: bus.status_in[FLAG_N],
                      z: bus.status_in[FLAG_Z],
                      c: bus.status_in[FLAG_C],
                      v: bus.status_in[FLAG_V]};

  pipe_reg #(.WIDTH(32)) u_pc (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill), .d(bus.pc_in), .q(bus.pc_out)
  );

  pipe_reg #(.WIDTH(32)) u_val_rn (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill), .d(bus.val_rn_in), .q(bus.val_rn_out)
  );

  pipe_reg #(.WIDTH(32)) u_val_rm (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill), .d(bus.val_rm_in), .q(bus.val_rm_out)
  );

  pipe_reg #(.WIDTH(37)) u_opnd (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill),
    .d({bus.shift_operand_in, bus.imm_in, bus.signed_imm_24_in}), .q(opnd_q)
  );

  pipe_reg #(.WIDTH(13)) u_ctl (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill),
    .d({bus.exe_cmd_in, ctrl_d, bus.dest_in}), .q(ctl_q)
  );

  pipe_reg #(.WIDTH(8)) u_src (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill),
    .d({bus.src1_in, bus.src2_in}), .q(src_q)
  );

  pipe_reg #(.WIDTH(STATUS_W)) u_status (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill), .d(status_d), .q(status_q)
  );

  // Val2 takes the immediate offset whenever the instruction touches memory.
  pipe_reg #(.WIDTH(1)) u_mem_sel (
    .clk(clk), .rst(rst), .en(load_en), .clr(kill),
    .d(ctrl_d.mem_r_en | ctrl_d.mem_w_en), .q(bus.mem_sel_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else if (load_en) begin
      valid_q <= ~kill;
      if (kill) begin
        bubble_cnt_q <= sat_inc(bubble_cnt_q);
      end
    end
  end

  assign {bus.shift_operand_out, bus.imm_out, bus.signed_imm_24_out} = opnd_q;
  assign {bus.exe_cmd_out, bus.ctrl_out, bus.dest_out}               = ctl_q;
  assign {bus.src1_out, bus.src2_out}                                = src_q;
  assign bus.status_out = status_q;
  assign bus.valid_out  = valid_q;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule
